// File: rtl/frog_pkg.sv
// Shared definitions for the frog 4-bit CPU bus: opcode nibbles, responder
// states and default bus widths.
package frog_pkg;

    localparam int FROG_AW = 6;
    localparam int FROG_DW = 4;

    localparam logic [3:0] OP_NGA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_ORR = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_NOP = 4'h8;
    localparam logic [3:0] OP_LDA = 4'h9;
    localparam logic [3:0] OP_LDB = 4'hA;
    localparam logic [3:0] OP_LDI = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_JPZ = 4'hD;
    localparam logic [3:0] OP_STA = 4'hE;
    localparam logic [3:0] OP_STB = 4'hF;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } resp_state_t;

endpackage

// File: rtl/frog_mem_array.sv
// 2**AW x DW storage with one synchronous write port, one asynchronous read
// port, and a synchronous fill of every word while rst_p is high.
module frog_mem_array
    import frog_pkg::*;
#(
    parameter int              AW       = FROG_AW,
    parameter int              DW       = FROG_DW,
    parameter logic [DW-1:0]   FILL_VAL = OP_NOP
) (
    input  logic          clk,
    input  logic          rst_p,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Reset fill takes priority so an interrupted load never leaves stale code.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= FILL_VAL;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/frog_bus_responder.sv
// Memory-side responder for the frog CPU bus with a nibble-stream program loader.
// Optional CPU write protection of the low region: define FROG_RESP_WRITE_PROTECT_EN.
module frog_bus_responder
    import frog_pkg::*;
#(
    parameter int            AW          = FROG_AW,
    parameter int            DW          = FROG_DW,
    parameter int            HOLD_CYCLES = 4,
    parameter logic [DW-1:0] FILL_VAL    = OP_NOP
`ifdef FROG_RESP_WRITE_PROTECT_EN
    ,
    parameter logic [AW-1:0] PROT_TOP    = AW'('h1F)
`endif
) (
    input  logic          clk,
    input  logic          rst_p,
    input  logic [AW-1:0] bus_daout,
    input  logic          bus_wcyc,
    output logic [DW-1:0] bus_data,
    output logic          cpu_rst_p,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_nibble,
    output logic          ld_ready,
    output logic          ld_done
`ifdef FROG_RESP_WRITE_PROTECT_EN
    ,
    output logic          wp_hit
`endif
);

    localparam int            HC_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [AW-1:0] PTR_LAST  = '1;

    resp_state_t   state;
    logic [HC_W-1:0] hold_cnt;
    logic [AW-1:0] ptr;
    logic [AW-1:0] addr_q;

    logic          cpu_drop;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

`ifdef FROG_RESP_WRITE_PROTECT_EN
    assign cpu_drop = (addr_q <= PROT_TOP);

    always_ff @(posedge clk) begin
        if (rst_p) begin
            wp_hit <= 1'b0;
        end else begin
            wp_hit <= (state == RUN) && bus_wcyc && cpu_drop;
        end
    end
`else
    assign cpu_drop = 1'b0;
`endif

    // Write cycles carry data only, so their target is the last read-cycle address.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            addr_q <= '0;
        end else if (!bus_wcyc) begin
            addr_q <= bus_daout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            ptr       <= '0;
            cpu_rst_p <= 1'b1;
            ld_ready  <= 1'b0;
            ld_done   <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                HOLD: begin
                    cpu_rst_p <= 1'b1;
                    if (ld_start) begin
                        state    <= LOAD;
                        hold_cnt <= '0;
                        ptr      <= '0;
                        ld_ready <= 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= RUN;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                // Release lags entry by one cycle, giving the core a full HOLD_CYCLES+1 reset.
                RUN: begin
                    if (ld_start) begin
                        state     <= LOAD;
                        ptr       <= '0;
                        cpu_rst_p <= 1'b1;
                        ld_ready  <= 1'b1;
                    end else begin
                        cpu_rst_p <= 1'b0;
                    end
                end
                LOAD: begin
                    cpu_rst_p <= 1'b1;
                    if (ld_start) begin
                        ptr <= ld_valid ? AW'(1) : '0;
                    end else if (ld_valid) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == PTR_LAST) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= HOLD;
                    cpu_rst_p <= 1'b1;
                    ld_ready  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = bus_daout[DW-1:0];
        if (state == LOAD) begin
            if (ld_valid) begin
                mem_we    = 1'b1;
                mem_waddr = ld_start ? '0 : ptr;
                mem_wdata = ld_nibble;
            end
        end else if ((state == RUN) && bus_wcyc && !cpu_drop) begin
            mem_we = 1'b1;
        end
    end

    frog_mem_array #(
        .AW       (AW),
        .DW       (DW),
        .FILL_VAL (FILL_VAL)
    ) u_mem (
        .clk   (clk),
        .rst_p (rst_p),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (bus_daout),
        .rdata (mem_rdata)
    );

    assign bus_data = ((state == RUN) && !bus_wcyc) ? mem_rdata : FILL_VAL;

endmodule

// File: tb/tb_frog_bus_responder.sv
// Directed self-checking bench for frog_bus_responder; exercises the
// FROG_RESP_WRITE_PROTECT_EN build when that macro is defined.
module tb_frog_bus_responder;

    logic       clk = 1'b0;
    logic       rst_p;
    logic [5:0] bus_daout;
    logic       bus_wcyc;
    logic [3:0] bus_data;
    logic       cpu_rst_p;
    logic       ld_start;
    logic       ld_valid;
    logic [3:0] ld_nibble;
    logic       ld_ready;
    logic       ld_done;
`ifdef FROG_RESP_WRITE_PROTECT_EN
    logic       wp_hit;
`endif

    int checks   = 0;
    int failures = 0;
    int done_cnt;
    int bad_cnt;

    always #5 clk = ~clk;

    frog_bus_responder dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .bus_daout (bus_daout),
        .bus_wcyc  (bus_wcyc),
        .bus_data  (bus_data),
        .cpu_rst_p (cpu_rst_p),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_nibble (ld_nibble),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done)
`ifdef FROG_RESP_WRITE_PROTECT_EN
        ,
        .wp_hit    (wp_hit)
`endif
    );

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (ld_done === 1'b1) done_cnt++;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic readCheck(input string tag, input logic [5:0] addr, input logic [3:0] expected);
        bus_wcyc  = 1'b0;
        bus_daout = addr;
        #1;
        checkOutput(tag, {4'h0, bus_data}, {4'h0, expected});
    endtask

    task automatic scanAll(input logic [3:0] expected);
        bad_cnt = 0;
        bus_wcyc = 1'b0;
        for (int a = 0; a < 64; a++) begin
            bus_daout = 6'(a);
            #1;
            if (bus_data !== expected) bad_cnt++;
        end
    endtask

    initial begin
        rst_p     = 1'b1;
        bus_daout = 6'h00;
        bus_wcyc  = 1'b0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_nibble = 4'h0;
        done_cnt  = 0;

        // Reset state and hold release timing
        applyStimulus();
        applyStimulus();
        checkOutput("rst_cpu_rst", {7'h0, cpu_rst_p}, 8'h1);
        checkOutput("rst_ld_ready", {7'h0, ld_ready}, 8'h0);
        checkOutput("rst_ld_done", {7'h0, ld_done}, 8'h0);
        checkOutput("rst_bus_data", {4'h0, bus_data}, 8'h8);
        rst_p = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("hold_cyc%0d", i), {7'h0, cpu_rst_p}, 8'h1);
        end
        applyStimulus();
        checkOutput("hold_release", {7'h0, cpu_rst_p}, 8'h0);
        readCheck("idle_read_2A", 6'h2A, 4'h8);

        // Full 64-nibble load, nibble i = i[3:0]
        ld_start = 1'b1;
        applyStimulus();
        ld_start = 1'b0;
        checkOutput("load_ready", {7'h0, ld_ready}, 8'h1);
        checkOutput("load_cpu_rst", {7'h0, cpu_rst_p}, 8'h1);
        done_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            ld_valid  = 1'b1;
            ld_nibble = 4'(i);
            applyStimulus();
        end
        ld_valid = 1'b0;
        checkOutput("load_done_pulse", {7'h0, ld_done}, 8'h1);
        checkOutput("load_ready_drop", {7'h0, ld_ready}, 8'h0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("load_hold%0d", i), {7'h0, cpu_rst_p}, 8'h1);
        end
        applyStimulus();
        checkOutput("load_release", {7'h0, cpu_rst_p}, 8'h0);
        checkOutput("load_done_count", 8'(done_cnt), 8'h1);
        readCheck("load_read_13", 6'h13, 4'h3);
        readCheck("load_read_3F", 6'h3F, 4'hF);

        // Single CPU write to the last read address
        bus_daout = 6'h20;
        bus_wcyc  = 1'b0;
        applyStimulus();
        bus_daout = 6'h05;
        bus_wcyc  = 1'b1;
        #1;
        checkOutput("wcyc_bus_data_fill", {4'h0, bus_data}, 8'h8);
        applyStimulus();
        readCheck("wr_read_20", 6'h20, 4'h5);
        readCheck("wr_read_21", 6'h21, 4'h1);

        // Back-to-back writes: last one wins
        bus_daout = 6'h24;
        bus_wcyc  = 1'b0;
        applyStimulus();
        bus_daout = 6'h09;
        bus_wcyc  = 1'b1;
        applyStimulus();
        bus_daout = 6'h0C;
        applyStimulus();
        readCheck("b2b_read_24", 6'h24, 4'hC);
        readCheck("b2b_read_25", 6'h25, 4'h5);

        // Abort after 10 nibbles, restart with a coincident first nibble
        done_cnt  = 0;
        ld_start  = 1'b1;
        applyStimulus();
        ld_start  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ld_valid  = 1'b1;
            ld_nibble = 4'h3;
            applyStimulus();
        end
        ld_start  = 1'b1;
        ld_nibble = 4'hA;
        applyStimulus();
        ld_start  = 1'b0;
        for (int i = 1; i < 64; i++) begin
            applyStimulus();
        end
        ld_valid = 1'b0;
        checkOutput("restart_done_pulse", {7'h0, ld_done}, 8'h1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
        end
        checkOutput("restart_release", {7'h0, cpu_rst_p}, 8'h0);
        checkOutput("restart_done_count", 8'(done_cnt), 8'h1);
        scanAll(4'hA);
        checkOutput("restart_all_A_bad", 8'(bad_cnt), 8'h0);

        // Loader nibbles outside LOAD are dropped
        ld_valid  = 1'b1;
        ld_nibble = 4'h3;
        applyStimulus();
        ld_valid  = 1'b0;
        readCheck("stray_valid_read_00", 6'h00, 4'hA);

        // Reset during a load refills memory
        ld_start = 1'b1;
        applyStimulus();
        ld_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ld_valid  = 1'b1;
            ld_nibble = 4'h5;
            applyStimulus();
        end
        rst_p = 1'b1;
        applyStimulus();
        rst_p    = 1'b0;
        ld_valid = 1'b0;
        checkOutput("midrst_cpu_rst", {7'h0, cpu_rst_p}, 8'h1);
        checkOutput("midrst_ld_ready", {7'h0, ld_ready}, 8'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
        end
        checkOutput("midrst_release", {7'h0, cpu_rst_p}, 8'h0);
        scanAll(4'h8);
        checkOutput("midrst_all_8_bad", 8'(bad_cnt), 8'h0);

`ifdef FROG_RESP_WRITE_PROTECT_EN
        // Protected region drops CPU writes; upper region commits
        bus_daout = 6'h10;
        bus_wcyc  = 1'b0;
        applyStimulus();
        bus_daout = 6'h07;
        bus_wcyc  = 1'b1;
        applyStimulus();
        checkOutput("wp_hit_pulse", {7'h0, wp_hit}, 8'h1);
        bus_wcyc = 1'b0;
        applyStimulus();
        checkOutput("wp_hit_clear", {7'h0, wp_hit}, 8'h0);
        readCheck("wp_read_10", 6'h10, 4'h8);
        bus_daout = 6'h30;
        bus_wcyc  = 1'b0;
        applyStimulus();
        bus_daout = 6'h06;
        bus_wcyc  = 1'b1;
        applyStimulus();
        checkOutput("wp_hit_none", {7'h0, wp_hit}, 8'h0);
        readCheck("wp_read_30", 6'h30, 4'h6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frog_bus_responder.md
Name: frog_bus_responder

Overview:
- Memory-side responder for the frog 4-bit CPU bus.
- Holds a 64x4 unified program/data memory and answers CPU read cycles with same-cycle data.
- Commits CPU write cycles to memory.
- Includes a nibble-stream loader that fills memory while holding the CPU in reset, then releases it.
- Sits beside the CPU core in the top level, replacing the bench-side lookup table.

Parameters:
- AW, 6, bus address width (memory depth 2**AW).
- DW, 4, data nibble width.
- HOLD_CYCLES, 4, cycles cpu_rst_p stays high after reset or load completion before release.
- FILL_VAL, 4'h8, value written to every location on reset (OP_NOP).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_p  in  1  synchronous active-high reset.
- bus_daout  in  AW  CPU address/data output.
- bus_wcyc  in  1  CPU write-cycle flag.
- bus_data  out  DW  read data to CPU data input.
- cpu_rst_p  out  1  reset to CPU core, active-high.
- ld_start  in  1  one-cycle pulse: begin program load.
- ld_valid  in  1  loader nibble valid.
- ld_nibble  in  DW  loader nibble.
- ld_ready  out  1  responder accepts loader nibble this cycle.
- ld_done  out  1  one-cycle pulse when the 64th nibble is accepted.

Behaviour:
- Interface: one clock, clk. Reset rst_p is synchronous and active-high.
- Bus protocol:
  - bus_wcyc=0 is a read cycle; bus_daout is the address.
  - bus_wcyc=1 is a write cycle; bus_daout[DW-1:0] is write data to addr_q.
  - addr_q is registered on every clock with bus_wcyc=0 (last read-cycle address).
- Read path: bus_data = mem[bus_daout] combinationally when bus_wcyc=0 and state=RUN. Otherwise bus_data=FILL_VAL.
- Write path: on a clk edge with state=RUN and bus_wcyc=1, mem[addr_q] <= bus_daout[3:0].
  - Consecutive write cycles all target the same addr_q; the last one wins.
  - A read in the cycle after a write returns the new value.
- FSM states: HOLD, LOAD, RUN.
  - Reset: state=HOLD, hold_cnt=0, ptr=0, addr_q=0, every mem word=FILL_VAL. Outputs: cpu_rst_p=1, ld_ready=0, ld_done=0.
  - HOLD: cpu_rst_p=1, hold_cnt increments. When hold_cnt==HOLD_CYCLES-1, go to RUN and clear hold_cnt. Net effect: cpu_rst_p low on the (HOLD_CYCLES+1)th edge after reset deasserts.
  - RUN: cpu_rst_p=0. ld_start goes to LOAD with ptr=0 and cpu_rst_p=1 from the next cycle. Any CPU write in that same cycle is still committed.
  - LOAD: cpu_rst_p=1, ld_ready=1, CPU writes ignored.
    - On ld_valid&ld_ready: mem[ptr] <= ld_nibble, ptr++.
    - Accepting at ptr==63: ptr wraps to 0, ld_done pulses, go to HOLD.
    - ld_start in LOAD restarts (ptr=0). If ld_valid coincides, that nibble is written to address 0 and ptr becomes 1.
  - ld_start in HOLD goes to LOAD and aborts the hold.
- Reset mid-LOAD: abandons the load and refills memory with FILL_VAL. rst_p has priority over every other input.
- ld_valid outside LOAD is ignored; nothing is written.

Optional Feature:
- Macro FROG_RESP_WRITE_PROTECT_EN.
- Defined:
  - Adds parameter PROT_TOP (default 6'h1F).
  - CPU write cycles with addr_q<=PROT_TOP are dropped.
  - Adds output wp_hit (1 bit), high for one cycle after each dropped write, reset 0.
  - Loader writes are never protected.
- Undefined: no wp_hit port, and all CPU writes commit.

Decomposition:
- Package frog_pkg:
  - OP_NGA..OP_STB opcode constants (4'h0..4'hF, OP_NOP=4'h8).
  - Responder state enum {HOLD, LOAD, RUN}.
  - AW/DW defaults.
- One sub-module, frog_mem_array:
  - 2**AW x DW storage, single write port, async read port.
  - Synchronous fill-on-reset.
- FSM, loader and write steering stay in frog_bus_responder.

Test Plan:
- Reset then idle: cpu_rst_p=1 for exactly 4 cycles after rst_p falls, then 0. Read of addr 6'h2A returns 4'h8.
- Load 64 nibbles (nibble i = i[3:0]):
  - ld_done pulses once, and cpu_rst_p releases 4 cycles later.
  - Reads of 6'h13 return 4'h3 and 6'h3F return 4'hF.
- CPU write: read cycle at 6'h20, then wcyc=1 with daout=6'h05. A later read of 6'h20 returns 4'h5 while 6'h21 is unchanged.
- Back-to-back writes: read 6'h24, then wcyc data 4'h9 followed by 4'hC. mem[6'h24]=4'hC.
- Abort and restart load:
  - ld_start, 10 nibbles, ld_start again, then 64 nibbles of 4'hA.
  - All locations read 4'hA, and ld_done pulses exactly once.
- Reset mid-LOAD after 20 nibbles: all locations read 4'h8, state HOLD, ld_ready=0. With FROG_RESP_WRITE_PROTECT_EN, a write to 6'h10 is dropped with a wp_hit pulse, and a write to 6'h30 commits.
